sram_axi_slave: RTL

AXI4 slave that fronts a word-addressed on-chip SRAM holding instruction or data memory, sitting on the downstream side of the bus that the CPU wrapper's M0/M1 master ports drive. It accepts single-beat and INCR burst reads and writes, serialises them through one FSM, applies per-byte write strobes, and returns R/B responses with the transaction ID. One instance is placed per memory (IM, DM) behind the interconnect.

---
 rtl/sram_axi_slave.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_slave.sv
// -----------------------------------------------------------------------------
// sram_axi_slave
//
// AXI4 slave in front of a word-addressed on-chip SRAM (one instance per
// instruction or data memory). Single-beat and INCR bursts are serialised
// through one FSM, and only one transaction is in flight at a time. Every
// access is treated as a 32-bit INCR. AxSIZE and AxBURST are ignored.
//
// Optional feature macro: SRAM_SLV_ERR_EN
//   When it is defined, a beat whose unwrapped word address is at or above
//   MEM_WORDS has these effects:
//     - a read beat returns SLVERR with zero data;
//     - a write beat is suppressed and the burst ends with BRESP=SLVERR.
//   When it is undefined, addresses alias modulo MEM_WORDS and every
//   response is OKAY.
//
// Ports
//   ACLK, ARESETn                : clock, asynchronous active-low reset
//   AW* / AWVALID / AWREADY      : write address channel
//   WDATA/WSTRB/WLAST/WVALID/WREADY : write data channel
//   BID/BRESP/BVALID/BREADY      : write response channel
//   AR* / ARVALID / ARREADY      : read address channel
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY : read data channel
// -----------------------------------------------------------------------------
module sram_axi_slave #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 16384
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RDATA,
    S_WDATA,
    S_WRESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [WA_W-1:0]         waddr_q, waddr_d;
  logic [4:0]              beats_q, beats_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic [IDX_W-1:0]        idx;
  logic                    oor;
  logic                    aw_hs, ar_hs, w_hs, r_hs, b_hs;
  logic                    last_beat;
  logic                    mem_we;
  logic                    unused_inputs;

  // The full word address is tracked without wrapping. The SRAM index is
  // its low bits, so the index itself wraps modulo MEM_WORDS.
  assign idx = waddr_q[IDX_W-1:0];

`ifdef SRAM_SLV_ERR_EN
  assign oor = |waddr_q[WA_W-1:IDX_W];
  assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, AWADDR[1:0], ARADDR[1:0]};
`else
  assign oor = 1'b0;
  assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, AWADDR[1:0], ARADDR[1:0],
                           waddr_q[WA_W-1:IDX_W]};
`endif

  // When AW and AR arrive together in IDLE, AR is held off so the write wins.
  assign aw_hs     = (state_q == S_IDLE) && AWVALID;
  assign ar_hs     = (state_q == S_IDLE) && ARVALID && !AWVALID;
  assign w_hs      = (state_q == S_WDATA) && WVALID;
  assign r_hs      = (state_q == S_RDATA) && RREADY;
  assign b_hs      = (state_q == S_WRESP) && BREADY;
  assign last_beat = (beats_q == 5'd1);
  assign mem_we    = w_hs && !oor;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      waddr_q <= '0;
      beats_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      waddr_q <= waddr_d;
      beats_q <= beats_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (aw_hs)      state_d = S_WDATA;
        else if (ar_hs) state_d = S_RREQ;
      end
      S_RREQ:  state_d = S_RDATA;
      S_RDATA: if (r_hs) state_d = last_beat ? S_IDLE : S_RREQ;
      S_WDATA: if (w_hs && WLAST) state_d = S_WRESP;
      S_WRESP: if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The read data is captured in RREQ and held in rdata_q for the whole
  // RDATA state, which keeps RDATA stable under R backpressure. The write
  // beat count is only loaded. WLAST alone ends a write burst.
  always_comb begin
    id_d    = id_q;
    waddr_d = waddr_q;
    beats_d = beats_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    err_d   = err_q;
    if (aw_hs) begin
      id_d    = AWID;
      waddr_d = AWADDR[ADDR_WIDTH-1:2];
      beats_d = {1'b0, AWLEN} + 5'd1;
      err_d   = 1'b0;
    end else if (ar_hs) begin
      id_d    = ARID;
      waddr_d = ARADDR[ADDR_WIDTH-1:2];
      beats_d = {1'b0, ARLEN} + 5'd1;
    end
    if (state_q == S_RREQ) begin
      rdata_d = oor ? '0 : mem[idx];
      rresp_d = oor ? RESP_SLVERR : RESP_OKAY;
    end
    if (r_hs && !last_beat) begin
      waddr_d = waddr_q + WA_W'(1);
      beats_d = beats_q - 5'd1;
    end
    if (w_hs) begin
      waddr_d = waddr_q + WA_W'(1);
      err_d   = err_q | oor;
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (WSTRB[i]) mem[idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    AWREADY = (state_q == S_IDLE);
    ARREADY = (state_q == S_IDLE) && !AWVALID;
    WREADY  = (state_q == S_WDATA);
    BVALID  = (state_q == S_WRESP);
    RVALID  = (state_q == S_RDATA);
    RLAST   = (state_q == S_RDATA) && last_beat;
    RDATA   = rdata_q;
    RRESP   = rresp_q;
    RID     = id_q;
    BID     = id_q;
    BRESP   = err_q ? RESP_SLVERR : RESP_OKAY;
  end

endmodule
